// File: rtl/fetch_buffer_if.sv
// Fetch front-end bus bundle: imem request/response, execute redirect and decode output.
// master = fetch_buffer side, slave = memory/execute/decode side.
interface fetch_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic [CW-1:0]   fb_count;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, fb_count,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, fb_count,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// Decoupled instruction fetcher: owns the fetch PC, buffers up to DEPTH {pc, instr} entries.
// Optional macro FETCH_BYPASS_EN: response goes straight to decode when the buffer is empty.
module fetch_buffer #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            rst,
  fetch_buffer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] out_pc_q;
  logic [XLEN-1:0] out_instr_q;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [CW:0]     credits_used;
  logic [CW-1:0]   outstanding_nxt;
  logic [AW-1:0]   rd_next;
  logic            req_valid;
  logic            req_fire;
  logic            rsp_ok;
  logic            rsp_drop;
  logic            rsp_take;
  logic            pop_buf;
  logic            byp;
  logic            byp_take;
  logic            push;

  assign credits_used = {1'b0, occ} + {1'b0, outstanding};
  assign req_valid    = !rst && !bus.redirect_valid && (credits_used < (CW+1)'(DEPTH));
  assign req_fire     = req_valid && bus.imem_req_ready;

  // Stray responses with nothing outstanding are ignored so counters never underflow.
  assign rsp_ok   = bus.imem_rsp_valid && (outstanding != '0);
  assign rsp_drop = rsp_ok && (drop_cnt != '0);
  assign rsp_take = rsp_ok && (drop_cnt == '0) && !bus.redirect_valid;
  assign pop_buf  = (occ != '0) && bus.out_ready;

`ifdef FETCH_BYPASS_EN
  assign byp      = (occ == '0) && (drop_cnt == '0) && !bus.redirect_valid && rsp_ok;
  assign byp_take = byp && bus.out_ready;
`else
  assign byp      = 1'b0;
  assign byp_take = 1'b0;
`endif

  assign push            = rsp_take && !byp_take;
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_ok);
  assign rd_next         = rd_ptr + AW'(1);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.out_valid      = (occ != '0) || byp;
  assign bus.out_pc         = byp ? rsp_pc : out_pc_q;
  assign bus.out_instr      = byp ? bus.imem_rsp_data : out_instr_q;
  assign bus.fb_count       = occ;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= bus.imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      occ         <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (bus.redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        occ      <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        rsp_pc   <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        drop_cnt <= outstanding_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
        if (rsp_take) rsp_pc   <= rsp_pc + XLEN'(4);
        if (push)     wr_ptr   <= wr_ptr + AW'(1);
        if (pop_buf)  rd_ptr   <= rd_next;
        occ <= occ + CW'(push) - CW'(pop_buf);
        // Head registers track the next entry; a push into an emptying buffer becomes head.
        if (pop_buf && (occ > CW'(1))) begin
          out_pc_q    <= pc_mem[rd_next];
          out_instr_q <= instr_mem[rd_next];
        end else if (push && ((occ == '0) || (pop_buf && (occ == CW'(1))))) begin
          out_pc_q    <= rsp_pc;
          out_instr_q <= bus.imem_rsp_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer against a queue-level transaction model.
module tb_fetch_buffer;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; logic stale; } req_t;
  typedef struct { logic [31:0] addr; int due; } mrsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ent_t        fbq[$];
  req_t        pend[$];
  mrsp_t       memq[$];
  logic [31:0] m_fetch_pc;
  int          cyc;
  int          last_due;
  int          checks;
  int          errors;
  int          lat_min;
  int          lat_max;
  int          rsp_pct;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input logic rst_i, input logic ready_i, input logic ordy_i,
                      input logic redir_i, input logic [31:0] rpc_i,
                      input logic stray_i, input logic chk);
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic        e_ov;
    logic        byp;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        pop;
    int          lat;
    int          due;
    req_t        r;
    @(negedge clk);
    rv = 1'b0;
    rd = $urandom();
    if (!rst_i) begin
      if (memq.size() > 0) begin
        if (memq[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
          rv = 1'b1;
          rd = instr_of(memq[0].addr);
        end
      end else if (stray_i) begin
        rv = 1'b1;
      end
    end
    rst                = rst_i;
    bus.imem_req_ready = ready_i;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rd;
    bus.redirect_valid = redir_i;
    bus.redirect_pc    = rpc_i;
    bus.out_ready      = ordy_i;
    #1;
    e_req = !rst_i && !redir_i && (fbq.size() + pend.size() < DEPTH);
    byp   = 1'b0;
`ifdef FETCH_BYPASS_EN
    if (fbq.size() == 0 && pend.size() > 0 && !redir_i && rv)
      byp = !pend[0].stale;
`endif
    e_ov    = (fbq.size() != 0) || byp;
    e_pc    = 32'h0;
    e_instr = 32'h0;
    if (byp) begin
      e_pc    = pend[0].addr;
      e_instr = rd;
    end else if (fbq.size() != 0) begin
      e_pc    = fbq[0].pc;
      e_instr = fbq[0].instr;
    end
    if (chk) begin
      check_val("req_valid", 32'(bus.imem_req_valid), 32'(e_req));
      check_val("req_addr", bus.imem_req_addr, m_fetch_pc);
      check_val("out_valid", 32'(bus.out_valid), 32'(e_ov));
      check_val("fb_count", 32'(bus.fb_count), 32'(fbq.size()));
      if (e_ov) begin
        check_val("out_pc", bus.out_pc, e_pc);
        check_val("out_instr", bus.out_instr, e_instr);
      end
    end
    if (rst_i) begin
      fbq.delete();
      pend.delete();
      memq.delete();
      m_fetch_pc = RESET_PC;
      last_due   = 0;
    end else begin
      pop = e_ov && ordy_i;
      if (pop && !byp) void'(fbq.pop_front());
      if (rv) begin
        if (memq.size() > 0) void'(memq.pop_front());
        if (pend.size() > 0) begin
          r = pend.pop_front();
          if (!r.stale && !redir_i && !(byp && ordy_i))
            fbq.push_back('{pc: r.addr, instr: rd});
        end
      end
      if (e_req && ready_i) begin
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (due < last_due) due = last_due;
        last_due = due;
        pend.push_back('{addr: m_fetch_pc, stale: 1'b0});
        memq.push_back('{addr: m_fetch_pc, due: due});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (redir_i) begin
        fbq.delete();
        foreach (pend[i]) pend[i].stale = 1'b1;
        m_fetch_pc = rpc_i & 32'hFFFF_FFFC;
      end
    end
    cyc++;
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int ready_pct, input int ordy_pct,
                     input int redir_pct, input int rst_pct);
    logic [31:0] rpc;
    for (int i = 0; i < n; i++) begin
      rpc = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                     : ($urandom() & 32'h0000_0FFF);
      step($urandom_range(99) < rst_pct, $urandom_range(99) < ready_pct,
           $urandom_range(99) < ordy_pct, $urandom_range(99) < redir_pct,
           rpc, 1'b0, 1'b1);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    last_due = 0;
    lat_min  = 1;
    lat_max  = 1;
    rsp_pct  = 100;
    m_fetch_pc = RESET_PC;
    rst                = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;

    do_reset();
    peek();
    check_val("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check_val("rst_req_addr", bus.imem_req_addr, RESET_PC);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_val("rst_out_pc", bus.out_pc, 32'h0);
    check_val("rst_out_instr", bus.out_instr, 32'h0);
    check_val("rst_fb_count", 32'(bus.fb_count), 32'h0);

    // Stray response with nothing outstanding, then streaming at 1-cycle latency.
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    run(40, 100, 100, 0, 0);

    // Decode stall fills the buffer and throttles requests.
    do_reset();
    run(12, 100, 0, 0, 0);
    peek();
    check_val("stall_fb_count", 32'(bus.fb_count), 32'(DEPTH));
    check_val("stall_req_valid", 32'(bus.imem_req_valid), 32'h0);
    check_val("stall_req_addr", bus.imem_req_addr, 32'h10);
    run(20, 100, 100, 0, 0);

    // Redirect with three requests in flight at latency 3.
    do_reset();
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 20 && pend.size() < 3; i++)
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    check_val("redir_setup_outstanding", 32'(pend.size()), 32'd3);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0, 1'b1);
    check_val("redir_next_addr", m_fetch_pc, 32'h100);
    run(20, 100, 100, 0, 0);

    // Redirect coinciding with a response and an output handshake.
    lat_min = 1;
    lat_max = 1;
    do_reset();
    run(6, 100, 100, 0, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
    run(12, 100, 100, 0, 0);

    // Reset mid-stream with three entries buffered.
    do_reset();
    for (int i = 0; i < 20 && fbq.size() < 3; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    peek();
    check_val("mid_fb_count", 32'(bus.fb_count), 32'd3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    peek();
    check_val("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_val("mid_rst_fb_count", 32'(bus.fb_count), 32'h0);
    check_val("mid_rst_req_addr", bus.imem_req_addr, RESET_PC);

    // Randomized traffic: variable latency, backpressure, redirects, resets.
    lat_min = 1;
    lat_max = 4;
    rsp_pct = 80;
    run(3000, 70, 60, 4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
